// File: rtl/pic_host_sequencer.sv
// Host-side sequencer for an 8259-style PIC: runs the ICW/OCW1 init sequence,
// the two-pulse INTA acknowledge with vector capture, and one-shot host writes.
// All bus outputs are registered and decoded from the next state, so strobes
// are glitch-free and reset forces the bus idle at once.
module pic_host_sequencer #(
  parameter logic [7:0]  ICW1_VAL   = 8'h13,
  parameter logic [7:0]  ICW2_VAL   = 8'h20,
  parameter logic [7:0]  ICW3_VAL   = 8'h00,
  parameter logic [7:0]  ICW4_VAL   = 8'h01,
  parameter logic [7:0]  OCW1_VAL   = 8'h00,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned GAP_CYC    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_init,
  output logic       init_done,
  input  logic       host_wr_req,
  input  logic       host_wr_a0,
  input  logic [7:0] host_wr_data,
  output logic       host_wr_ack,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  input  logic       vec_ready,
  input  logic       pic_int,
  output logic       pic_cs_n,
  output logic       pic_wr_n,
  output logic       pic_rd_n,
  output logic       pic_inta_n,
  output logic       pic_a0,
  output logic [7:0] pic_d_out,
  output logic       pic_d_oe,
  input  logic [7:0] pic_d_in
);

  localparam int unsigned MAX_CYC = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  // Counter load values: a phase lasts (load + 1) cycles and ends at zero.
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYC - 1);

  // ICW1 mode bits that decide whether ICW3 / ICW4 are part of the sequence.
  localparam bit SNGL = ICW1_VAL[1];
  localparam bit IC4  = ICW1_VAL[0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_WR,
    S_READY,
    S_HOST_WR,
    S_INTA1,
    S_INTA_GAP,
    S_INTA2
  } state_e;

  // Sub-phase of a bus operation. Write ops use all four; INTA2 uses
  // STROBE then GAP (the post-capture idle time).
  typedef enum logic [1:0] {
    P_SETUP,
    P_STROBE,
    P_HOLD,
    P_GAP
  } phase_e;

  typedef enum logic [2:0] {
    I_ICW1,
    I_ICW2,
    I_ICW3,
    I_ICW4,
    I_OCW1
  } init_step_e;

  // Next init register after the given one, skipping optional ICW3/ICW4.
  function automatic init_step_e next_step(input init_step_e step);
    case (step)
      I_ICW1:  next_step = I_ICW2;
      I_ICW2:  next_step = !SNGL ? I_ICW3 : (IC4 ? I_ICW4 : I_OCW1);
      I_ICW3:  next_step = IC4 ? I_ICW4 : I_OCW1;
      default: next_step = I_OCW1;
    endcase
  endfunction

  // Byte written for each init register.
  function automatic logic [7:0] step_byte(input init_step_e step);
    case (step)
      I_ICW1:  step_byte = ICW1_VAL;
      I_ICW2:  step_byte = ICW2_VAL;
      I_ICW3:  step_byte = ICW3_VAL;
      I_ICW4:  step_byte = ICW4_VAL;
      default: step_byte = OCW1_VAL;
    endcase
  endfunction

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  init_step_e       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_done;
  logic             is_wr_d;

  logic             vec_valid_q, vec_valid_d;
  logic [7:0]       vec_data_q, vec_data_d;
  logic             a0_q, a0_d;
  logic [7:0]       d_out_q, d_out_d;
  logic             cs_n_q, cs_n_d;
  logic             wr_n_q, wr_n_d;
  logic             inta_n_q, inta_n_d;
  logic             d_oe_q, d_oe_d;
  logic             init_done_q, init_done_d;
  logic             ack_q, ack_d;

  // Next-state, phase counter, vector buffer and registered bus outputs.
  always_comb begin
    // NOTE: every variable is given its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    vec_valid_d = vec_valid_q;
    vec_data_d  = vec_data_q;
    a0_d        = a0_q;
    d_out_d     = d_out_q;
    cnt_done    = (cnt_q == '0);

    // Host handshake on the vector buffer; a new capture can only happen
    // while the buffer is empty, so this never collides with INTA2.
    if (vec_valid_q && vec_ready) begin
      vec_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_init) begin
          state_d = S_INIT_WR;
          phase_d = P_SETUP;
          step_d  = I_ICW1;
          a0_d    = 1'b0;
          d_out_d = step_byte(I_ICW1);
        end
      end

      S_READY: begin
        if (start_init) begin
          state_d = S_INIT_WR;
          phase_d = P_SETUP;
          step_d  = I_ICW1;
          a0_d    = 1'b0;
          d_out_d = step_byte(I_ICW1);
        end else if (pic_int && !vec_valid_q) begin
          state_d = S_INTA1;
          phase_d = P_STROBE;
          cnt_d   = STROBE_LOAD;
        end else if (host_wr_req) begin
          state_d = S_HOST_WR;
          phase_d = P_SETUP;
          a0_d    = host_wr_a0;
          d_out_d = host_wr_data;
        end
      end

      S_INIT_WR, S_HOST_WR: begin
        case (phase_q)
          P_SETUP: begin
            phase_d = P_STROBE;
            cnt_d   = STROBE_LOAD;
          end
          P_STROBE: begin
            if (cnt_done) begin
              phase_d = P_HOLD;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          P_HOLD: begin
            phase_d = P_GAP;
            cnt_d   = GAP_LOAD;
          end
          default: begin
            if (!cnt_done) begin
              cnt_d = cnt_q - 1'b1;
            end else if ((state_q == S_INIT_WR) && (step_q != I_OCW1)) begin
              phase_d = P_SETUP;
              step_d  = next_step(step_q);
              a0_d    = 1'b1;
              d_out_d = step_byte(next_step(step_q));
            end else begin
              state_d = S_READY;
            end
          end
        endcase
      end

      S_INTA1: begin
        if (cnt_done) begin
          state_d = S_INTA_GAP;
          phase_d = P_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_INTA_GAP: begin
        if (cnt_done) begin
          state_d = S_INTA2;
          phase_d = P_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_INTA2: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 1'b1;
        end else if (phase_q == P_STROBE) begin
          // Last cycle of the second pulse: the PIC is driving the vector.
          vec_valid_d = 1'b1;
          vec_data_d  = pic_d_in;
          phase_d     = P_GAP;
          cnt_d       = GAP_LOAD;
        end else begin
          state_d = S_READY;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus outputs follow the state being entered, so the registered copies
    // line up exactly with the phase they describe.
    is_wr_d     = (state_d == S_INIT_WR) || (state_d == S_HOST_WR);
    cs_n_d      = !(is_wr_d && (phase_d != P_GAP));
    wr_n_d      = !(is_wr_d && (phase_d == P_STROBE));
    d_oe_d      = !cs_n_d;
    inta_n_d    = !((state_d == S_INTA1) ||
                    ((state_d == S_INTA2) && (phase_d == P_STROBE)));
    init_done_d = (state_d == S_READY);
    ack_d       = (state_d == S_HOST_WR) && (phase_d == P_HOLD);
  end

  // State, counter and output registers; reset parks the bus idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= P_SETUP;
      step_q      <= I_ICW1;
      cnt_q       <= '0;
      vec_valid_q <= 1'b0;
      vec_data_q  <= 8'h00;
      a0_q        <= 1'b0;
      d_out_q     <= 8'h00;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      inta_n_q    <= 1'b1;
      d_oe_q      <= 1'b0;
      init_done_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      vec_valid_q <= vec_valid_d;
      vec_data_q  <= vec_data_d;
      a0_q        <= a0_d;
      d_out_q     <= d_out_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      inta_n_q    <= inta_n_d;
      d_oe_q      <= d_oe_d;
      init_done_q <= init_done_d;
      ack_q       <= ack_d;
    end
  end

  assign init_done   = init_done_q;
  assign host_wr_ack = ack_q;
  assign vec_valid   = vec_valid_q;
  assign vec_data    = vec_data_q;
  assign pic_cs_n    = cs_n_q;
  assign pic_wr_n    = wr_n_q;
  assign pic_rd_n    = 1'b1;
  assign pic_inta_n  = inta_n_q;
  assign pic_a0      = a0_q;
  assign pic_d_out   = d_out_q;
  assign pic_d_oe    = d_oe_q;

endmodule
